// File: rtl/rf_access_ctrl_if.sv
// Port bundle between the register-file access controller and its environment:
// decode op offer, ALU completion, debug requester and register-file controls.
interface rf_access_ctrl_if #(
    parameter int ADDR = 4,
    parameter int SIZE = 32
);
    logic            Op_Valid;
    logic            Op_Ready;
    logic [ADDR-1:0] Op_Rn;
    logic [ADDR-1:0] Op_Rm;
    logic [ADDR-1:0] Op_Rs;
    logic [ADDR-1:0] Op_Rd;
    logic            Op_Use_Rs;
    logic            Op_WB;
    logic            ALU_Done;
    logic [SIZE-1:0] ALU_Result;
    logic            Done;
    logic            Err;
    logic            Dbg_Req;
    logic            Dbg_Wr;
    logic [ADDR-1:0] Dbg_Addr;
    logic [SIZE-1:0] Dbg_W_Data;
    logic            Dbg_Gnt;
    logic            Dbg_Ack;
    logic            LA;
    logic            LB;
    logic            LC;
    logic            Write_Reg;
    logic [ADDR-1:0] R_Addr_A;
    logic [ADDR-1:0] R_Addr_B;
    logic [ADDR-1:0] R_Addr_C;
    logic [ADDR-1:0] W_Addr;
    logic [SIZE-1:0] W_Data;

    // Controller side
    modport slave (
        input  Op_Valid, Op_Rn, Op_Rm, Op_Rs, Op_Rd, Op_Use_Rs, Op_WB,
        input  ALU_Done, ALU_Result,
        input  Dbg_Req, Dbg_Wr, Dbg_Addr, Dbg_W_Data,
        output Op_Ready, Done, Err, Dbg_Gnt, Dbg_Ack,
        output LA, LB, LC, Write_Reg, R_Addr_A, R_Addr_B, R_Addr_C, W_Addr, W_Data
    );

    // Environment side: decode, datapath, debug host and register file
    modport master (
        output Op_Valid, Op_Rn, Op_Rm, Op_Rs, Op_Rd, Op_Use_Rs, Op_WB,
        output ALU_Done, ALU_Result,
        output Dbg_Req, Dbg_Wr, Dbg_Addr, Dbg_W_Data,
        input  Op_Ready, Done, Err, Dbg_Gnt, Dbg_Ack,
        input  LA, LB, LC, Write_Reg, R_Addr_A, R_Addr_B, R_Addr_C, W_Addr, W_Data
    );
endinterface

// File: rtl/rf_access_ctrl.sv
// Sequences one data-processing op through READ/EXEC/WB on the 3R/1W register
// file and shares its ports with a debug requester; all outputs are registered.
module rf_access_ctrl #(
    parameter int ADDR    = 4,
    parameter int SIZE    = 32,
    parameter int TIMEOUT = 15
) (
    input logic           clk,
    input logic           Rst_n,
    rf_access_ctrl_if.slave bus
);
    localparam int CW = 5;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_READ    = 3'd1,
        S_EXEC    = 3'd2,
        S_WB      = 3'd3,
        S_DBG     = 3'd4,
        S_DBG_ACK = 3'd5
    } state_e;

    state_e          state_q, state_d;
    logic            last_dbg_q, last_dbg_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [ADDR-1:0] rd_q, rd_d;
    logic            wb_q, wb_d;

    logic            op_ready_q, op_ready_d;
    logic            dbg_gnt_q, dbg_gnt_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic            dbg_ack_q, dbg_ack_d;
    logic            la_q, la_d;
    logic            lb_q, lb_d;
    logic            lc_q, lc_d;
    logic            wr_q, wr_d;
    logic [ADDR-1:0] ra_q, ra_d;
    logic [ADDR-1:0] rb_q, rb_d;
    logic [ADDR-1:0] rc_q, rc_d;
    logic [ADDR-1:0] wa_q, wa_d;
    logic [SIZE-1:0] wd_q, wd_d;

    logic op_acc_s;
    logic dbg_acc_s;

    assign op_acc_s  = (state_q == S_IDLE) && op_ready_q && bus.Op_Valid;
    assign dbg_acc_s = (state_q == S_IDLE) && dbg_gnt_q && bus.Dbg_Req;

    // Next state plus next value of every registered output
    always_comb begin
        state_d    = state_q;
        last_dbg_d = last_dbg_q;
        cnt_d      = cnt_q;
        rd_d       = rd_q;
        wb_d       = wb_q;
        op_ready_d = 1'b0;
        dbg_gnt_d  = 1'b0;
        done_d     = 1'b0;
        err_d      = 1'b0;
        dbg_ack_d  = 1'b0;
        la_d       = 1'b0;
        lb_d       = 1'b0;
        lc_d       = 1'b0;
        wr_d       = 1'b0;
        ra_d       = ra_q;
        rb_d       = rb_q;
        rc_d       = rc_q;
        wa_d       = wa_q;
        wd_d       = wd_q;

        case (state_q)
            S_IDLE: begin
                if (op_acc_s) begin
                    state_d    = S_READ;
                    last_dbg_d = 1'b0;
                    rd_d       = bus.Op_Rd;
                    wb_d       = bus.Op_WB;
                    la_d       = 1'b1;
                    lb_d       = 1'b1;
                    lc_d       = bus.Op_Use_Rs;
                    ra_d       = bus.Op_Rn;
                    rb_d       = bus.Op_Rm;
                    rc_d       = bus.Op_Rs;
                end else if (dbg_acc_s) begin
                    state_d    = S_DBG;
                    last_dbg_d = 1'b1;
                    if (bus.Dbg_Wr) begin
                        wr_d = 1'b1;
                        wa_d = bus.Dbg_Addr;
                        wd_d = bus.Dbg_W_Data;
                    end else begin
                        la_d = 1'b1;
                        ra_d = bus.Dbg_Addr;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_READ: begin
                state_d = S_EXEC;
                cnt_d   = {CW{1'b0}};
            end
            S_EXEC: begin
                // Completion wins over a timeout reached in the same cycle
                if (bus.ALU_Done) begin
                    done_d = 1'b1;
                    if (wb_q) begin
                        state_d = S_WB;
                        wr_d    = 1'b1;
                        wa_d    = rd_q;
                        wd_d    = bus.ALU_Result;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            S_WB: begin
                state_d = S_IDLE;
            end
            S_DBG: begin
                state_d   = S_DBG_ACK;
                dbg_ack_d = 1'b1;
            end
            S_DBG_ACK: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Grants are issued for the next IDLE cycle; the Done/Err cycle that
        // follows EXEC carries no grant so Op_Ready reappears one cycle later.
        if ((state_d == S_IDLE) && (state_q != S_EXEC)) begin
            if (bus.Op_Valid && bus.Dbg_Req) begin
                op_ready_d = last_dbg_q;
                dbg_gnt_d  = ~last_dbg_q;
            end else begin
                op_ready_d = bus.Op_Valid;
                dbg_gnt_d  = bus.Dbg_Req;
            end
        end else begin
            op_ready_d = 1'b0;
            dbg_gnt_d  = 1'b0;
        end
    end

    // State, captured op fields and registered outputs
    always_ff @(posedge clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q    <= S_IDLE;
            last_dbg_q <= 1'b0;
            cnt_q      <= {CW{1'b0}};
            rd_q       <= {ADDR{1'b0}};
            wb_q       <= 1'b0;
            op_ready_q <= 1'b0;
            dbg_gnt_q  <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            dbg_ack_q  <= 1'b0;
            la_q       <= 1'b0;
            lb_q       <= 1'b0;
            lc_q       <= 1'b0;
            wr_q       <= 1'b0;
            ra_q       <= {ADDR{1'b0}};
            rb_q       <= {ADDR{1'b0}};
            rc_q       <= {ADDR{1'b0}};
            wa_q       <= {ADDR{1'b0}};
            wd_q       <= {SIZE{1'b0}};
        end else begin
            state_q    <= state_d;
            last_dbg_q <= last_dbg_d;
            cnt_q      <= cnt_d;
            rd_q       <= rd_d;
            wb_q       <= wb_d;
            op_ready_q <= op_ready_d;
            dbg_gnt_q  <= dbg_gnt_d;
            done_q     <= done_d;
            err_q      <= err_d;
            dbg_ack_q  <= dbg_ack_d;
            la_q       <= la_d;
            lb_q       <= lb_d;
            lc_q       <= lc_d;
            wr_q       <= wr_d;
            ra_q       <= ra_d;
            rb_q       <= rb_d;
            rc_q       <= rc_d;
            wa_q       <= wa_d;
            wd_q       <= wd_d;
        end
    end

    assign bus.Op_Ready  = op_ready_q;
    assign bus.Dbg_Gnt   = dbg_gnt_q;
    assign bus.Done      = done_q;
    assign bus.Err       = err_q;
    assign bus.Dbg_Ack   = dbg_ack_q;
    assign bus.LA        = la_q;
    assign bus.LB        = lb_q;
    assign bus.LC        = lc_q;
    assign bus.Write_Reg = wr_q;
    assign bus.R_Addr_A  = ra_q;
    assign bus.R_Addr_B  = rb_q;
    assign bus.R_Addr_C  = rc_q;
    assign bus.W_Addr    = wa_q;
    assign bus.W_Data    = wd_q;
endmodule

// File: doc/rf_access_ctrl.md
# rf_access_ctrl

Sequencer and arbiter for the 3-read/1-write register file in the data-processing CPU. Accepts one data-processing operation at a time from the decode stage, drives the register file's read-latch enables (LA/LB/LC), read addresses, and write port through READ -> EXEC -> WRITEBACK, and shares the same ports with a debug requester. The register file samples on negedge clk. This block updates its outputs on posedge, so each control value is stable when the register file samples it mid-cycle.

## Interface
- ADDR, 4, register address width
- SIZE, 32, data width
- TIMEOUT, 15, max EXEC cycles waiting for ALU_Done (1..2^5-1)

- clk  in  1  clock, posedge
- Rst_n  in  1  asynchronous, active-low reset
- Op_Valid  in  1  decode offers an operation
- Op_Ready  out  1  controller accepts the operation (IDLE and granted)
- Op_Rn, Op_Rm, Op_Rs, Op_Rd  in  ADDR each  source and destination registers
- Op_Use_Rs  in  1  operation reads Rs (register-specified shift)
- Op_WB  in  1  result is written back (0 for CMP/TST-type)
- ALU_Done  in  1  datapath result valid this cycle
- ALU_Result  in  SIZE  datapath result
- Done  out  1  one-cycle pulse when an operation retires
- Err  out  1  one-cycle pulse on EXEC timeout
- Dbg_Req, Dbg_Wr  in  1 each  debug access request; 1 = write
- Dbg_Addr  in  ADDR  debug register address
- Dbg_W_Data  in  SIZE  debug write data
- Dbg_Gnt  out  1  debug request accepted this cycle
- Dbg_Ack  out  1  debug access complete; read data valid on register file R_Data_A
- LA, LB, LC, Write_Reg  out  1 each  register file controls
- R_Addr_A, R_Addr_B, R_Addr_C, W_Addr  out  ADDR each  register file addresses
- W_Data  out  SIZE  register file write data

## Operation
- States: IDLE, READ, EXEC, WB, DBG, DBG_ACK. All outputs are registered.
- Arbitration (IDLE only):
  - Op_Valid alone: Op_Ready=1.
  - Dbg_Req alone: Dbg_Gnt=1.
  - Both asserted: round-robin on a last-winner flag. The flag resets to "op", so debug wins the first contention, and the winner alternates after that.
  - Op_Ready and Dbg_Gnt are never high together.
- On op acceptance: capture Rn/Rm/Rs/Rd/Use_Rs/WB, then go to READ.
- READ, 1 cycle:
  - LA=1 with R_Addr_A=Rn.
  - LB=1 with R_Addr_B=Rm.
  - LC=Op_Use_Rs with R_Addr_C=Rs.
  - Next state: EXEC.
- EXEC:
  - Clear the timeout counter on entry.
  - On ALU_Done: capture ALU_Result. Go to WB if WB=1. Otherwise pulse Done and return to IDLE.
  - After TIMEOUT cycles with no ALU_Done: pulse Err, return to IDLE, and perform no write.
- WB, 1 cycle:
  - Write_Reg=1, W_Addr=Rd, W_Data=captured result, Done=1.
  - Next state: IDLE.
- On debug grant: capture Dbg_Wr, Dbg_Addr and Dbg_W_Data, then go to DBG.
- DBG, 1 cycle:
  - Write access: Write_Reg=1, W_Addr=addr, W_Data=data.
  - Read access: LA=1, R_Addr_A=addr.
  - Next state: DBG_ACK.
- DBG_ACK, 1 cycle: Dbg_Ack=1. R_Data_A holds the read value, because LA is now low. Next state: IDLE.
- Between uses, addresses and W_Data hold their last values. Enables are 0 outside the states listed above.

## Timing
- Reset:
  - State goes to IDLE and the last-winner flag to "op".
  - Every output is 0, including addresses and W_Data.
  - An in-flight operation is aborted with no write and no Done.
- Op latency (accept edge = cycle 0):
  - READ enables in cycle 1.
  - EXEC from cycle 2.
  - If ALU_Done arrives in cycle 2+k: WB/Done in cycle 3+k when WB=1, or Done in cycle 3+k with no write when WB=0.
  - Op_Ready returns in cycle 4+k.
- Debug latency (grant = cycle 0): DBG in cycle 1, Dbg_Ack in cycle 2, next grant possible in cycle 3.
- Requests arriving while not in IDLE wait. Requesters hold Valid/Req and fields until accepted.
- An ALU_Done pulse outside EXEC is ignored.
- ALU_Done arriving in the same cycle the counter reaches TIMEOUT counts as a completion, not an Err.
- Rd equal to Rn, Rm or Rs is legal, because the read precedes the write by at least two cycles.

## Test plan
- Reset, then Op Rn=1, Rm=2, Rd=3, WB=1, with ALU_Done 2 cycles into EXEC and ALU_Result=0x12345678 -> LA/LB high in READ with addresses 1/2, LC=0; Write_Reg pulse with W_Addr=3 and W_Data=0x12345678; Done asserted in the same cycle as Write_Reg.
- Op with WB=0 and Use_Rs=1, Rs=4 -> LC=1 with R_Addr_C=4; Done pulses; Write_Reg never asserts.
- ALU_Done never asserted, TIMEOUT=15 -> Err pulse 15 cycles after EXEC entry; no Write_Reg; Op_Ready high the next cycle.
- Debug write addr 5, data 0xA5A5A5A5, followed by debug read addr 5 -> Write_Reg pulse; then LA with R_Addr_A=5; Dbg_Ack with R_Data_A=0xA5A5A5A5.
- Op_Valid and Dbg_Req both held continuously for 4 grants -> grant order debug, op, debug, op; Op_Ready and Dbg_Gnt never high together.
- Rst_n asserted low during EXEC after ALU_Done has been captured -> all outputs 0 immediately; no Write_Reg or Done follows; normal operation resumes after release.
